fetch_prefetch: RTL

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small prefetch queue
// ahead of the if_id registers. Optional macro FETCH_BYPASS_EN forwards a response straight to if_id.
module fetch_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'd64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_if_stall,
  input  logic              id_if_selpcsource,
  input  logic [ADDR_W-1:0] id_if_rega,
  input  logic [ADDR_W-1:0] id_if_pcimd2ext,
  input  logic [ADDR_W-1:0] id_if_pcindex,
  input  logic [1:0]        id_if_selpctype,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [ADDR_W-1:0] mc_if_data,
  input  logic              mc_if_valid,
  output logic [ADDR_W-1:0] if_id_instruc,
  output logic [ADDR_W-1:0] if_id_nextpc,
  output logic              if_id_valid
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              discard_r;
  logic [ADDR_W-1:0] q_instr_r [DEPTH];
  logic [ADDR_W-1:0] q_npc_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] instr_r;
  logic [ADDR_W-1:0] npc_r;
  logic              valid_r;

  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              resp_s;
  logic              take_s;
  logic              empty_s;
  logic              issue_s;
  logic              pop_s;
  logic              push_s;
  logic              bypass_s;

  // A response only counts while a request is outstanding; a redirect in the same cycle voids it.
  assign resp_s    = busy_r & mc_if_valid;
  assign take_s    = resp_s & ~discard_r & ~id_if_selpcsource;
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign issue_s   = ~busy_r & (count_r < FULL_CNT) & ~id_if_selpcsource;
  assign pop_s     = ~id_if_selpcsource & ~ex_if_stall & ~empty_s;
  assign next_pc_s = pc_r + PC_STEP;
`ifdef FETCH_BYPASS_EN
  assign bypass_s  = take_s & empty_s & ~ex_if_stall;
`else
  assign bypass_s  = 1'b0;
`endif
  assign push_s    = take_s & ~bypass_s;

  // Redirect target selection.
  always_comb begin
    target_s = EXC_VECTOR;
    case (id_if_selpctype)
      2'b00:   target_s = id_if_pcimd2ext;
      2'b01:   target_s = id_if_rega;
      2'b10:   target_s = id_if_pcindex;
      default: target_s = EXC_VECTOR;
    endcase
  end

  // Fetch PC and memory request handshake; an outstanding request stays on the bus across a redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      addr_r    <= RESET_PC;
      busy_r    <= 1'b0;
      discard_r <= 1'b0;
    end else if (id_if_selpcsource) begin
      pc_r      <= target_s;
      busy_r    <= busy_r & ~mc_if_valid;
      discard_r <= busy_r & ~mc_if_valid;
    end else if (resp_s) begin
      busy_r    <= 1'b0;
      discard_r <= 1'b0;
      if (!discard_r) begin
        pc_r <= next_pc_s;
      end
    end else if (issue_s) begin
      busy_r <= 1'b1;
      addr_r <= pc_r;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (id_if_selpcsource) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; entries are only read while counted as valid, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      q_instr_r[wr_ptr_r] <= mc_if_data;
      q_npc_r[wr_ptr_r]   <= next_pc_s;
    end
  end

  // if_id stage registers: frozen under stall, invalidated by redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_r <= {ADDR_W{1'b0}};
      npc_r   <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (id_if_selpcsource) begin
      valid_r <= 1'b0;
    end else if (!ex_if_stall) begin
      if (bypass_s) begin
        instr_r <= mc_if_data;
        npc_r   <= next_pc_s;
        valid_r <= 1'b1;
      end else if (pop_s) begin
        instr_r <= q_instr_r[rd_ptr_r];
        npc_r   <= q_npc_r[rd_ptr_r];
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  assign if_mc_en      = busy_r;
  assign if_mc_addr    = addr_r;
  assign if_id_instruc = instr_r;
  assign if_id_nextpc  = npc_r;
  assign if_id_valid   = valid_r;

endmodule
